wptr_full_ctrl: RTL
===================

// Module: wptr_full_ctrl
// PURPOSE
//  Write-side pointer and full-flag controller of the asynchronous FIFO; sits in the write clock domain.
//  Keeps the binary and Gray write pointers and drives the RAM write address.
//  Publishes the Gray write pointer to the read-domain 2-flop synchronizer.
//  Consumes the read pointer that has been synchronized into this domain and derives full, almost-full, level and overflow.
// PARAMETERS
//  ADDRSIZE      4  address bits; DEPTH = 2**ADDRSIZE entries; must be >= 2
//  AFULL_MARGIN  2  walmost_full asserts when level >= DEPTH-AFULL_MARGIN; range 1..DEPTH-1
// PORTS
//  clk           in   1           write-domain clock
//  rst_n         in   1           asynchronous, active-low reset
//  winc          in   1           write request; accepted only when wfull==0
//  wq2_rptr      in   ADDRSIZE+1  Gray read pointer, already synchronized into clk
//  wovf_clr      in   1           clears sticky wovf
//  waddr         out  ADDRSIZE    RAM write address = wbin[ADDRSIZE-1:0]
//  wptr          out  ADDRSIZE+1  registered Gray write pointer, to the read-side synchronizer
//  wfull         out  1           registered FIFO-full flag
//  walmost_full  out  1           registered almost-full flag
//  wlevel        out  ADDRSIZE+1  registered occupancy estimate, 0..DEPTH
//  wovf          out  1           sticky flag: write attempted while full
// BEHAVIOUR
//  Reset (async, any time incl. mid-burst):
//   - wbin, wptr, wfull, walmost_full, wlevel, wovf all = 0; waddr = 0.
//  Write acceptance:
//   - we = winc & ~wfull.
//   - wbinnext = wbin + we, modulo 2**(ADDRSIZE+1).
//   - wgraynext = (wbinnext>>1) ^ wbinnext.
//   - Each posedge: wbin <= wbinnext; wptr <= wgraynext.
//  waddr:
//   - Combinational from the wbin register. Constant between accepted writes.
//   - RAM writes at waddr on the same edge that we is high.
//  wfull:
//   - Each posedge: wfull <= (wgraynext == {~wq2_rptr[A:A-1], wq2_rptr[A-2:0]}), where A = ADDRSIZE.
//   - Rises on the edge of the write that fills the FIFO.
//   - Falls on the first edge after wq2_rptr advances.
//  Read-pointer conversion:
//   - rbin = Gray-to-binary(wq2_rptr) by XOR prefix chain, combinational.
//  Level:
//   - lvlnext = wbinnext - rbin, modulo 2**(ADDRSIZE+1).
//   - Each posedge: wlevel <= lvlnext.
//   - Pessimistic: the synchronized read pointer lags by 2+ cycles, so wlevel never under-reports.
//  Almost-full:
//   - Each posedge: walmost_full <= (lvlnext >= DEPTH-AFULL_MARGIN).
//   - wfull implies walmost_full.
//  Overflow:
//   - wovf set on any edge with winc & wfull.
//   - Cleared by wovf_clr; set wins if both occur in the same cycle.
//   - A rejected write leaves wbin and wptr unchanged.
//  Gray pointer rules:
//   - wptr changes by exactly one bit per accepted write, including wrap 2**(A+1)-1 -> 0.
//   - No combinational path from any input to wptr.
//  Simultaneous events:
//   - winc together with a wq2_rptr advance while full: write still rejected that cycle (wfull is registered).
//   - wfull deasserts on that edge.
// TESTING  (ADDRSIZE=4, AFULL_MARGIN=2, DEPTH=16)
//  1 Reset asserted mid-burst, wptr=5'b00110 -> all outputs 0 immediately, before the next clk edge.
//  2 wq2_rptr=0, 16 back-to-back winc:
//     - after the 14th write: walmost_full=1, wlevel=14.
//     - after the 16th write: wfull=1, wlevel=16, wptr=5'b11000, waddr=0.
//  3 FIFO full, winc=1 for 3 cycles -> wptr holds 5'b11000, wovf=1; pulse wovf_clr -> wovf=0 next edge.
//  4 Full, then wq2_rptr=5'b00001 (rbin=1) -> next edge: wfull=0, wlevel=15; one more write -> wfull=1.
//  5 Wrap test, reader tracking so the FIFO never fills:
//     - write 40 words.
//     - every wptr step is a 1-bit change, including 5'b10000 -> 5'b00000.
//     - waddr wraps 15 -> 0.
//  6 Same-cycle winc + wovf_clr while full -> wovf stays 1.

Source files
------------

// File: rtl/wptr_full_ctrl.sv
// Write-domain pointer/full controller for the async FIFO: binary and Gray write
// pointers, RAM write address, and full / almost-full / level / overflow flags.
module wptr_full_ctrl #(
    parameter int ADDRSIZE     = 4,
    parameter int AFULL_MARGIN = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                winc,
    input  logic [ADDRSIZE:0]   wq2_rptr,
    input  logic                wovf_clr,
    output logic [ADDRSIZE-1:0] waddr,
    output logic [ADDRSIZE:0]   wptr,
    output logic                wfull,
    output logic                walmost_full,
    output logic [ADDRSIZE:0]   wlevel,
    output logic                wovf
);

    localparam int              DEPTH    = 2 ** ADDRSIZE;
    localparam logic [ADDRSIZE:0] AFULL_TH = (ADDRSIZE + 1)'(DEPTH - AFULL_MARGIN);

    logic [ADDRSIZE:0] wbin;
    logic [ADDRSIZE:0] wbinnext;
    logic [ADDRSIZE:0] wgraynext;
    logic [ADDRSIZE:0] rbin;
    logic [ADDRSIZE:0] lvlnext;
    logic [ADDRSIZE:0] full_ptr;
    logic              we;

    assign we        = winc & ~wfull;
    assign wbinnext  = wbin + {{ADDRSIZE{1'b0}}, we};
    assign wgraynext = (wbinnext >> 1) ^ wbinnext;
    assign waddr     = wbin[ADDRSIZE-1:0];

    // Full when the write pointer is one lap ahead: top two Gray bits inverted.
    assign full_ptr  = {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]};

    always_comb begin
        rbin = '0;
        for (int i = 0; i <= ADDRSIZE; i++) begin
            rbin[i] = ^(wq2_rptr >> i);
        end
    end

    // The synchronized read pointer lags, so this level can only over-report.
    assign lvlnext = wbinnext - rbin;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbin         <= '0;
            wptr         <= '0;
            wfull        <= 1'b0;
            walmost_full <= 1'b0;
            wlevel       <= '0;
            wovf         <= 1'b0;
        end else begin
            wbin         <= wbinnext;
            wptr         <= wgraynext;
            wfull        <= (wgraynext == full_ptr);
            walmost_full <= (lvlnext >= AFULL_TH);
            wlevel       <= lvlnext;
            if (winc && wfull) begin
                wovf <= 1'b1;
            end else if (wovf_clr) begin
                wovf <= 1'b0;
            end
        end
    end

endmodule
